uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Oversampling UART receiver; counterpart of the UART_Tx serialiser.
//  Recovers frames from the serial line: start(0), Width data bits LSB first,
//  optional parity, stop(1). Presents P_DATA with a 1-cycle Data_valid pulse.
//  clk runs at Prescale x baud; sits between the RX pad and the system side.
// PARAMETERS
//  Width      8   data bits per frame
//  PRE_W      6   width of Prescale port
// PORTS
//  clk         in   1      receiver clock (Prescale x baud)
//  rst         in   1      asynchronous, active-low reset
//  RX_IN       in   1      serial line, idle high, asynchronous to clk
//  Prescale    in   PRE_W  oversampling ratio; legal: even, 4..62
//  PAR_EN      in   1      1 = frame carries a parity bit
//  PAR_TYP     in   1      0 = even, 1 = odd parity
//  P_DATA      out  Width  received data word
//  Data_valid  out  1      1-cycle pulse: P_DATA valid, frame error-free
//  Par_err     out  1      1-cycle pulse: parity mismatch
//  Stp_err     out  1      1-cycle pulse: stop bit sampled 0
//  Busy        out  1      high from start detect until return to IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE, counters 0, P_DATA=0, Data_valid/Par_err/Stp_err/Busy=0,
//    sync flops=1. Reset mid-frame aborts: no pulse, frame discarded.
//  - RX_IN passes a 2-flop synchroniser (rx_s); all logic uses rx_s.
//  - edge_cnt counts 0..Prescale-1 per bit; bit_cnt counts data bits.
//    Sample point: edge_cnt == Prescale>>1. Wrap to 0 at Prescale-1.
//  - Prescale, PAR_EN, PAR_TYP latched at start detect; changes mid-frame
//    ignored.
//  - FSM: IDLE  : rx_s==0 -> START, edge_cnt=1, Busy=1.
//         START : sample; 1 -> IDLE (glitch, no pulse); 0 -> DATA at wrap.
//         DATA  : sample into shift reg LSB first; after Width bits at wrap
//                 -> PARITY if PAR_EN else STOP.
//         PARITY: expected = ^data (even) / ~^data (odd); mismatch flag held.
//         STOP  : at sample point -> IDLE immediately (half-bit early, so a
//                 start bit directly after stop is caught).
//  - At stop sample: if stop==1 and no parity error: P_DATA<=data,
//    Data_valid=1 next cycle. Else Par_err and/or Stp_err=1 next cycle,
//    Data_valid=0, P_DATA unchanged. Both errors may pulse together.
//  - Busy drops the same cycle the pulses rise.
//  - Line low through entire frame (break): Stp_err pulse, then IDLE waits
//    for rx_s==1 before arming a new start detect.
// CONFIGURATION
//  UART_RX_MAJORITY_VOTE_EN defined: each bit = majority of samples at
//    edge_cnt = (Prescale>>1)-1, Prescale>>1, (Prescale>>1)+1; decision
//    made at (Prescale>>1)+1, all later timing referenced there.
//  Undefined: single sample at edge_cnt == Prescale>>1.
// TESTING
//  1 Prescale=8, PAR_EN=0, frame 0x81 -> P_DATA=0x81, one Data_valid pulse,
//    no errors, Busy high ~9.5 bit times.
//  2 Prescale=8, PAR_EN=1, PAR_TYP=0, 0x7F parity 1 -> valid 0x7F; same
//    frame with parity 0 -> Par_err pulse, Data_valid stays 0.
//  3 Prescale=16, PAR_TYP=1, 0x86 parity 0 -> valid 0x86; stop bit forced 0
//    -> Stp_err pulse, P_DATA keeps previous value.
//  4 RX_IN low for 2 clk in IDLE at Prescale=8 -> no pulses, Busy returns 0,
//    next real frame 0x55 received correctly.
//  5 Back-to-back frames 0xA5,0x3C with no idle gap -> two Data_valid pulses
//    ~10 bit times apart, correct data each.
//  6 rst low mid DATA state -> outputs 0 asynchronously; after release, frame
//    0x81 received correctly. With MAJORITY_VOTE_EN: 1-clk glitch at sample
//    point of a data bit -> data still correct.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : oversampling UART receiver
//
// Recovers frames of the form start(0), Width data bits LSB first, optional
// parity, stop(1) from an asynchronous serial line. clk runs at Prescale x
// baud. A good frame updates P_DATA and pulses Data_valid for one cycle.
// A bad frame pulses Par_err and/or Stp_err for one cycle instead.
//
// Ports
//   clk        in            receiver clock (Prescale x baud)
//   rst        in            asynchronous, active-low reset
//   RX_IN      in            serial line, idle high, asynchronous to clk
//   Prescale   in  [PRE_W]   oversampling ratio, even, 4..62
//   PAR_EN     in            1 = frame carries a parity bit
//   PAR_TYP    in            0 = even parity, 1 = odd parity
//   P_DATA     out [Width]   last error-free data word
//   Data_valid out           1-cycle pulse, P_DATA updated
//   Par_err    out           1-cycle pulse, parity mismatch
//   Stp_err    out           1-cycle pulse, stop bit sampled low
//   Busy       out           high from start detect until return to IDLE
//
// Build option
//   UART_RX_MAJORITY_VOTE_EN : each bit is the majority of three samples
//   around mid-bit, decided one clock after mid-bit. Undefined: a single
//   sample at mid-bit.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int Width = 8,
  parameter int PRE_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX_IN,
  input  logic [PRE_W-1:0] Prescale,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [Width-1:0] P_DATA,
  output logic             Data_valid,
  output logic             Par_err,
  output logic             Stp_err,
  output logic             Busy
);

  // state  | meaning
  // IDLE   | waiting for rx_s low (only once the line has been seen high)
  // START  | checking the start bit at its decision point
  // DATA   | shifting in Width data bits, LSB first
  // PARITY | checking the parity bit
  // STOP   | checking the stop bit, leave at its decision point
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int BW = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [BW-1:0]    LAST_BIT = BW'(Width - 1);
  localparam logic [BW-1:0]    ONE_B    = BW'(1);
  localparam logic [PRE_W-1:0] ONE_P    = PRE_W'(1);

  logic [1:0]       r_sync;
  state_t           r_state;
  logic [PRE_W-1:0] r_edge;
  logic [PRE_W-1:0] r_pre;
  logic [BW-1:0]    r_bit_cnt;
  logic [Width-1:0] r_shift;
  logic             r_par_en;
  logic             r_par_typ;
  logic             r_par_err;
  logic             r_armed;

  logic             w_rx;
  logic [PRE_W-1:0] w_half;
  logic             w_wrap;
  logic             w_sample;
  logic             w_bit;
  logic             w_par_exp;

  assign w_rx      = r_sync[1];
  assign w_half    = r_pre >> 1;
  assign w_wrap    = (r_edge == (r_pre - ONE_P));
  assign w_par_exp = r_par_typ ? ~(^r_shift) : (^r_shift);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic r_v0;
  logic r_v1;

  // Early and centre samples are kept; the decision uses the late sample
  // live, so every bit decision lands one clock after mid-bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v0 <= 1'b1;
      r_v1 <= 1'b1;
    end else begin
      if (r_edge == (w_half - ONE_P)) r_v0 <= w_rx;
      if (r_edge == w_half)           r_v1 <= w_rx;
    end
  end

  assign w_sample = (r_edge == (w_half + ONE_P));
  assign w_bit    = (r_v0 & r_v1) | (r_v0 & w_rx) | (r_v1 & w_rx);
`else
  assign w_sample = (r_edge == w_half);
  assign w_bit    = w_rx;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= 2'b11;
    else      r_sync <= {r_sync[0], RX_IN};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_edge     <= '0;
      r_pre      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_err  <= 1'b0;
      r_armed    <= 1'b1;
      P_DATA     <= '0;
      Data_valid <= 1'b0;
      Par_err    <= 1'b0;
      Stp_err    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Data_valid <= 1'b0;
      Par_err    <= 1'b0;
      Stp_err    <= 1'b0;

      if (r_state != S_IDLE) r_edge <= w_wrap ? '0 : (r_edge + ONE_P);

      case (r_state)
        S_IDLE: begin
          // After a break the line must return high before a new start
          // can be accepted, otherwise a held-low line re-triggers forever.
          if (w_rx) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state   <= S_START;
            r_edge    <= ONE_P;  // the detect cycle itself is edge 0
            Busy      <= 1'b1;
            r_pre     <= Prescale;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_par_err <= 1'b0;
            r_bit_cnt <= '0;
          end
        end

        S_START: begin
          if (w_sample && w_bit) begin
            r_state <= S_IDLE;
            r_edge  <= '0;
            Busy    <= 1'b0;
          end else if (w_wrap) begin
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_sample) r_shift <= {w_bit, r_shift[Width-1:1]};
          if (w_wrap) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + ONE_B;
            end
          end
        end

        S_PARITY: begin
          if (w_sample) r_par_err <= (w_bit != w_par_exp);
          if (w_wrap)   r_state   <= S_STOP;
        end

        S_STOP: begin
          // Leave at the decision point, half a bit early, so a start bit
          // immediately following the stop bit is not missed.
          if (w_sample) begin
            r_state <= S_IDLE;
            r_edge  <= '0;
            Busy    <= 1'b0;
            r_armed <= w_bit;
            if (w_bit && !r_par_err) begin
              P_DATA     <= r_shift;
              Data_valid <= 1'b1;
            end else begin
              Par_err <= r_par_err;
              Stp_err <= ~w_bit;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_edge  <= '0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int DEC_LAG = 1;
`else
  localparam int DEC_LAG = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_valid;
  logic       Par_err;
  logic       Stp_err;
  logic       Busy;

  uart_rx #(.Width(8), .PRE_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_valid (Data_valid),
    .Par_err    (Par_err),
    .Stp_err    (Stp_err),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  // Expected outcome of one frame, queued when the frame starts.
  typedef struct {
    logic [7:0] d;
    bit         perr;
    bit         serr;
    int         len;   // clocks Busy must have been high
  } exp_t;

  exp_t q[$];
  exp_t e;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int dv_cnt = 0, perr_cnt = 0, serr_cnt = 0, pulse_cnt = 0;
  int busy_run = 0, last_busy_len = 0;
  int dv_cyc_last = 0, dv_cyc_prev = 0;
  bit prev_busy = 0;
  logic [7:0] m_pdata = 8'h00;

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp_v, exp_v, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Compare process: checks every pulse against the queued frame outcome,
  // and P_DATA against the last good word on every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      m_pdata   = 8'h00;
      prev_busy = 0;
      busy_run  = 0;
    end else begin
      if (Data_valid || Par_err || Stp_err) begin
        pulse_cnt++;
        if (Data_valid) begin
          dv_cnt++;
          dv_cyc_prev = dv_cyc_last;
          dv_cyc_last = cyc;
        end
        if (Par_err) perr_cnt++;
        if (Stp_err) serr_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = q.pop_front();
          chk("data_valid", int'(Data_valid), int'(!(e.perr || e.serr)));
          chk("par_err", int'(Par_err), int'(e.perr));
          chk("stp_err", int'(Stp_err), int'(e.serr));
          chk("busy_at_pulse", int'(Busy), 0);
          chk("busy_len", busy_run, e.len);
          last_busy_len = busy_run;
          if (!(e.perr || e.serr)) m_pdata = e.d;
        end
      end
      chk("p_data", int'(P_DATA), int'(m_pdata));
      if (Busy) begin
        if (!prev_busy) busy_run = 0;
        busy_run++;
      end
      prev_busy = Busy;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a negedge. Config inputs are scrambled
  // after the start bit to show they are latched at start detect.
  task automatic send_frame(input logic [7:0] d, input int pre, input bit pen,
                            input bit ptyp, input bit pflip, input bit stopv,
                            input int gidx);
    logic [10:0] bits;
    logic        pb;
    int          n;
    exp_t        x;
    pb = (ptyp ? ~(^d) : (^d)) ^ pflip;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = 9;
    if (pen) begin
      bits[n] = pb;
      n = n + 1;
    end
    bits[n] = stopv;
    n = n + 1;
    Prescale = 6'(pre);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    x.d    = d;
    x.perr = pen && pflip;
    x.serr = !stopv;
    x.len  = (9 + int'(pen)) * pre + pre / 2 + DEC_LAG;
    q.push_back(x);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < pre; c++) begin
        if (b == gidx && c == pre / 2) RX_IN = ~bits[b];
        else                           RX_IN = bits[b];
        @(negedge clk);
      end
      if (b == 0) begin
        Prescale = 6'd30;
        PAR_EN   = !pen;
        PAR_TYP  = !ptyp;
      end
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    rst = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    idle(3);
    chk("rst_p_data", int'(P_DATA), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_valid", int'(Data_valid), 0);
    rst = 1'b1;
    idle(5);

    // 1: plain 8N1 frame
    send_frame(8'h81, 8, 0, 0, 0, 1, -1);
    idle(10);
    chk("t1_data", int'(P_DATA), 8'h81);
    chk("t1_busy_len", last_busy_len, 76 + DEC_LAG);
    chk("t1_pulses", pulse_cnt, 1);

    // 2: even parity good, then flipped parity
    send_frame(8'h7F, 8, 1, 0, 0, 1, -1);
    idle(10);
    chk("t2_data", int'(P_DATA), 8'h7F);
    send_frame(8'h7F, 8, 1, 0, 1, 1, -1);
    idle(10);
    chk("t2_par_err_cnt", perr_cnt, 1);
    chk("t2_valid_cnt", dv_cnt, 2);

    // 3: odd parity at Prescale 16, then stop bit low
    send_frame(8'h86, 16, 1, 1, 0, 1, -1);
    idle(20);
    chk("t3_data", int'(P_DATA), 8'h86);
    send_frame(8'h86, 16, 1, 1, 0, 0, -1);
    idle(20);
    chk("t3_stp_err_cnt", serr_cnt, 1);
    chk("t3_data_kept", int'(P_DATA), 8'h86);
    chk("t3_valid_cnt", dv_cnt, 3);

    // 4: 2-clock glitch in IDLE
    Prescale = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    idle(2);
    RX_IN = 1'b1;
    idle(20);
    chk("t4_busy_idle", int'(Busy), 0);
    chk("t4_no_pulse", pulse_cnt, 5);
    send_frame(8'h55, 8, 0, 0, 0, 1, -1);
    idle(10);
    chk("t4_data", int'(P_DATA), 8'h55);

    // 5: back-to-back frames
    send_frame(8'hA5, 8, 0, 0, 0, 1, -1);
    send_frame(8'h3C, 8, 0, 0, 0, 1, -1);
    idle(10);
    chk("t5_data", int'(P_DATA), 8'h3C);
    chk("t5_spacing", dv_cyc_last - dv_cyc_prev, 80);
    chk("t5_valid_cnt", dv_cnt, 6);

    // Break: line low for a whole frame and beyond
    Prescale = 6'd8; PAR_EN = 1'b0;
    e.d = 8'h00; e.perr = 0; e.serr = 1; e.len = 76 + DEC_LAG;
    q.push_back(e);
    RX_IN = 1'b0;
    idle(80 + 24);
    chk("brk_stp_err_cnt", serr_cnt, 2);
    chk("brk_no_rearm", int'(Busy), 0);
    RX_IN = 1'b1;
    idle(20);
    chk("brk_busy_after", int'(Busy), 0);
    chk("brk_data_kept", int'(P_DATA), 8'h3C);

    // 6: reset in the middle of DATA
    Prescale = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0; idle(8);
    RX_IN = 1'b1; idle(8);
    RX_IN = 1'b0; idle(12);
    chk("t6_busy_before", int'(Busy), 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_p_data", int'(P_DATA), 0);
    chk("t6_rst_busy", int'(Busy), 0);
    RX_IN = 1'b1;
    idle(3);
    rst = 1'b1;
    idle(20);
    chk("t6_no_pulse", int'(Data_valid), 0);
    send_frame(8'h81, 8, 0, 0, 0, 1, -1);
    idle(10);
    chk("t6_data", int'(P_DATA), 8'h81);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // single-clock glitch at the centre sample of data bit 3
    send_frame(8'h5A, 8, 0, 0, 0, 1, 4);
    idle(10);
    chk("mv_data", int'(P_DATA), 8'h5A);
`endif

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
